id_ex_hazard_stage: RTL and testbench

- ID/EX pipeline register with integrated load-use hazard control for the 5-stage core.
- Captures decoded operands, register numbers and control bits from ID.
- Presents register numbers and register-write flags to the forwarding unit in EX.
- Detects load-use dependencies, holds PC and IF/ID for a programmable number of bubbles, and squashes on a taken branch.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/load_use_detect.sv | 24 ++
 rtl/id_ex_hazard_stage.sv | 161 ++++++++++++++++
 tb/tb_id_ex_hazard_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Purpose: shared types and constants for the ID/EX stage and its hazard logic.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Contents: hazard FSM state type, register-address width, EX control
// bundle and the bubble value loaded into EX when an instruction is cancelled.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hazard_state_t;

  // Register numbers and write/load flags carried from ID into EX.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } ex_ctrl_t;

  // All-zero control: no write, no load, rd/rs = x0, so the forwarding
  // unit can never match against a bubble.
  localparam ex_ctrl_t EX_CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Purpose: combinational load-use compare between the load in EX and the ID sources.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the result feeds the stall FSM in the stage top.
// Ports: i_memread_ex/i_rd_ex describe the EX instruction, i_rs1_id/i_rs2_id the
// ID instruction's sources; o_hazard is high when ID must wait for the load.
module load_use_detect
  import cpu_pkg::*;
(
  input  logic                  i_memread_ex,
  input  logic [REG_ADDR_W-1:0] i_rd_ex,
  input  logic [REG_ADDR_W-1:0] i_rs1_id,
  input  logic [REG_ADDR_W-1:0] i_rs2_id,
  output logic                  o_hazard
);

  logic w_rd_nonzero;
  logic w_src_match;

  // A load into x0 produces nothing to wait for.
  assign w_rd_nonzero = (i_rd_ex != '0);
  assign w_src_match  = (i_rd_ex == i_rs1_id) || (i_rd_ex == i_rs2_id);
  assign o_hazard     = i_memread_ex && w_rd_nonzero && w_src_match;

endmodule

// File: rtl/id_ex_hazard_stage.sv
// Purpose: ID/EX pipeline register with load-use stall and taken-branch squash control.
// Latency: 1 cycle ID->EX when not stalled; pc_write/ifid_write/ifid_flush are combinational.
// Backpressure: holds PC and IF/ID (pc_write=ifid_write=0) for LOAD_STALL_CYCLES bubbles per load-use.
// Ports: clk/arst (async active-high) clocking; enable freezes all state when low;
// *_ID inputs are the decoded ID instruction; branch_taken_EX squashes IF/ID and EX;
// register_data1/2, rd_EX, regwrite_EX, memread_EX feed the forwarding unit;
// rdata1_EX/rdata2_EX/imm_EX are the registered operands; pc_write, ifid_write,
// ifid_flush steer the front end.
module id_ex_hazard_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W            = 64,
  parameter int LOAD_STALL_CYCLES = 1
)(
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  enable,
  input  logic [REG_ADDR_W-1:0] rs1_ID,
  input  logic [REG_ADDR_W-1:0] rs2_ID,
  input  logic [REG_ADDR_W-1:0] rd_ID,
  input  logic                  regwrite_ID,
  input  logic                  memread_ID,
  input  logic [DATA_W-1:0]     rdata1_ID,
  input  logic [DATA_W-1:0]     rdata2_ID,
  input  logic [DATA_W-1:0]     imm_ID,
  input  logic                  branch_taken_EX,
  output logic [REG_ADDR_W-1:0] register_data1,
  output logic [REG_ADDR_W-1:0] register_data2,
  output logic [REG_ADDR_W-1:0] rd_EX,
  output logic                  regwrite_EX,
  output logic                  memread_EX,
  output logic [DATA_W-1:0]     rdata1_EX,
  output logic [DATA_W-1:0]     rdata2_EX,
  output logic [DATA_W-1:0]     imm_EX,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush
);

  localparam int              CNT_W        = 2;
  // First bubble is issued from RUN; the counter covers the remaining ones.
  localparam logic [CNT_W-1:0] STALL_RELOAD = CNT_W'(LOAD_STALL_CYCLES - 1);

  hazard_state_t    r_state;
  hazard_state_t    w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  ex_ctrl_t         r_ex_ctrl;
  logic [DATA_W-1:0] r_rdata1;
  logic [DATA_W-1:0] r_rdata2;
  logic [DATA_W-1:0] r_imm;

  logic w_hazard;
  logic w_load_id;
  logic w_pc_write;
  logic w_ifid_write;
  logic w_ifid_flush;

  load_use_detect u_load_use_detect (
    .i_memread_ex (r_ex_ctrl.memread),
    .i_rd_ex      (r_ex_ctrl.rd),
    .i_rs1_id     (rs1_ID),
    .i_rs2_id     (rs2_ID),
    .o_hazard     (w_hazard)
  );

  // Next state and front-end controls. Any cycle that does not load the ID
  // instruction loads a bubble into EX.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_load_id    = 1'b0;
    w_pc_write   = 1'b1;
    w_ifid_write = 1'b1;
    w_ifid_flush = 1'b0;
    unique case (r_state)
      RUN: begin
        if (branch_taken_EX) begin
          // Branch wins over a simultaneous load-use: the dependent
          // instruction is on the wrong path anyway.
          w_state_nxt  = FLUSH;
          w_ifid_flush = 1'b1;
        end else if (w_hazard) begin
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_cnt_nxt    = STALL_RELOAD;
          w_state_nxt  = (STALL_RELOAD != '0) ? STALL : RUN;
        end else begin
          w_load_id = 1'b1;
        end
      end
      STALL: begin
        if (branch_taken_EX) begin
          w_state_nxt  = FLUSH;
          w_cnt_nxt    = '0;
          w_ifid_flush = 1'b1;
        end else begin
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_cnt_nxt    = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
          if (r_cnt <= CNT_W'(1)) begin
            w_state_nxt = RUN;
          end
        end
      end
      FLUSH: begin
        w_ifid_flush = 1'b1;
        w_state_nxt  = RUN;
      end
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end
    endcase
    // Frozen pipeline: nothing may advance or be cleared.
    if (!enable) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_ifid_flush = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state   <= RUN;
      r_cnt     <= '0;
      r_ex_ctrl <= EX_CTRL_BUBBLE;
      r_rdata1  <= '0;
      r_rdata2  <= '0;
      r_imm     <= '0;
    end else if (enable) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load_id) begin
        r_ex_ctrl <= '{rs1: rs1_ID, rs2: rs2_ID, rd: rd_ID,
                       regwrite: regwrite_ID, memread: memread_ID};
        r_rdata1  <= rdata1_ID;
        r_rdata2  <= rdata2_ID;
        r_imm     <= imm_ID;
      end else begin
        r_ex_ctrl <= EX_CTRL_BUBBLE;
        r_rdata1  <= '0;
        r_rdata2  <= '0;
        r_imm     <= '0;
      end
    end
  end

  assign register_data1 = r_ex_ctrl.rs1;
  assign register_data2 = r_ex_ctrl.rs2;
  assign rd_EX          = r_ex_ctrl.rd;
  assign regwrite_EX    = r_ex_ctrl.regwrite;
  assign memread_EX     = r_ex_ctrl.memread;
  assign rdata1_EX      = r_rdata1;
  assign rdata2_EX      = r_rdata2;
  assign imm_EX         = r_imm;
  assign pc_write       = w_pc_write;
  assign ifid_write     = w_ifid_write;
  assign ifid_flush     = w_ifid_flush;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Purpose: scoreboard bench for id_ex_hazard_stage, two instances (1 and 2 bubbles per load-use).
// Latency: expects EX contents one edge after issue, front-end controls in the same cycle.
// Backpressure: models PC/IF-ID hold as a per-instance count of bubbles still owed.
module tb_id_ex_hazard_stage;

  localparam int DW = 64;

  typedef struct packed {
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [4:0]    rd;
    logic          rw;
    logic          mr;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [DW-1:0] imm;
  } ex_t;

  logic          clk;
  logic          arst;
  logic          enable;
  logic [4:0]    rs1_id, rs2_id, rd_id;
  logic          rw_id, mr_id, br;
  logic [DW-1:0] d1_id, d2_id, imm_id;

  logic [4:0]    o_rs1 [2];
  logic [4:0]    o_rs2 [2];
  logic [4:0]    o_rd  [2];
  logic          o_rw  [2];
  logic          o_mr  [2];
  logic [DW-1:0] o_d1  [2];
  logic [DW-1:0] o_d2  [2];
  logic [DW-1:0] o_imm [2];
  logic          o_pcw [2];
  logic          o_ifw [2];
  logic          o_ifl [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what EX should hold, bubbles still owed, pending flush.
  ex_t m_ex      [2];
  int  m_owed    [2];
  bit  m_flushp  [2];
  int  stall_len [2];

  ex_t        ex_q[$];
  logic [2:0] ctrl_q[$];

  id_ex_hazard_stage #(.DATA_W(DW), .LOAD_STALL_CYCLES(1)) u_dut0 (
    .clk(clk), .arst(arst), .enable(enable),
    .rs1_ID(rs1_id), .rs2_ID(rs2_id), .rd_ID(rd_id),
    .regwrite_ID(rw_id), .memread_ID(mr_id),
    .rdata1_ID(d1_id), .rdata2_ID(d2_id), .imm_ID(imm_id),
    .branch_taken_EX(br),
    .register_data1(o_rs1[0]), .register_data2(o_rs2[0]), .rd_EX(o_rd[0]),
    .regwrite_EX(o_rw[0]), .memread_EX(o_mr[0]),
    .rdata1_EX(o_d1[0]), .rdata2_EX(o_d2[0]), .imm_EX(o_imm[0]),
    .pc_write(o_pcw[0]), .ifid_write(o_ifw[0]), .ifid_flush(o_ifl[0])
  );

  id_ex_hazard_stage #(.DATA_W(DW), .LOAD_STALL_CYCLES(2)) u_dut1 (
    .clk(clk), .arst(arst), .enable(enable),
    .rs1_ID(rs1_id), .rs2_ID(rs2_id), .rd_ID(rd_id),
    .regwrite_ID(rw_id), .memread_ID(mr_id),
    .rdata1_ID(d1_id), .rdata2_ID(d2_id), .imm_ID(imm_id),
    .branch_taken_EX(br),
    .register_data1(o_rs1[1]), .register_data2(o_rs2[1]), .rd_EX(o_rd[1]),
    .regwrite_EX(o_rw[1]), .memread_EX(o_mr[1]),
    .rdata1_EX(o_d1[1]), .rdata2_EX(o_d2[1]), .imm_EX(o_imm[1]),
    .pc_write(o_pcw[1]), .ifid_write(o_ifw[1]), .ifid_flush(o_ifl[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ex_t actual_ex(input int k);
    return '{rs1: o_rs1[k], rs2: o_rs2[k], rd: o_rd[k], rw: o_rw[k], mr: o_mr[k],
             d1: o_d1[k], d2: o_d2[k], imm: o_imm[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ex[k]     = '0;
      m_owed[k]   = 0;
      m_flushp[k] = 1'b0;
    end
  endtask

  // One cycle of the pipeline as described by its rules, for instance k.
  task automatic model_step(input int k, output logic [2:0] ctrl);
    ex_t id_v;
    bit  load_use;
    id_v = '{rs1: rs1_id, rs2: rs2_id, rd: rd_id, rw: rw_id, mr: mr_id,
             d1: d1_id, d2: d2_id, imm: imm_id};
    load_use = m_ex[k].mr && (m_ex[k].rd != 0) &&
               (m_ex[k].rd == rs1_id || m_ex[k].rd == rs2_id);
    if (!enable) begin
      ctrl = 3'b000;                 // {pc_write, ifid_write, ifid_flush}
    end else if (m_flushp[k]) begin
      ctrl = 3'b111;
      m_flushp[k] = 1'b0;
      m_ex[k] = '0;
    end else if (br) begin
      ctrl = 3'b111;
      m_flushp[k] = 1'b1;
      m_owed[k] = 0;
      m_ex[k] = '0;
    end else if (m_owed[k] > 0) begin
      ctrl = 3'b000;
      m_owed[k] = m_owed[k] - 1;
      m_ex[k] = '0;
    end else if (load_use) begin
      ctrl = 3'b000;
      m_owed[k] = stall_len[k] - 1;
      m_ex[k] = '0;
    end else begin
      ctrl = 3'b110;
      m_ex[k] = id_v;
    end
  endtask

  task automatic drive(input logic en, input logic b, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd,
                       input logic rw, input logic mr);
    logic [2:0] c;
    @(negedge clk);
    enable = en; br = b; rs1_id = r1; rs2_id = r2; rd_id = rd;
    rw_id = rw; mr_id = mr;
    d1_id  = {$urandom(), $urandom()};
    d2_id  = {$urandom(), $urandom()};
    imm_id = {$urandom(), $urandom()};
    for (int k = 0; k < 2; k++) begin
      model_step(k, c);
      ctrl_q.push_back(c);
      ex_q.push_back(m_ex[k]);
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (actual_ex(k) != '0) begin
        n_fail++;
        $display("FAIL %s_ex_dut%0d: got %h expected 0", tag, k, actual_ex(k));
      end
      n_tests++;
      if ({o_pcw[k], o_ifw[k], o_ifl[k]} != 3'b110) begin
        n_fail++;
        $display("FAIL %s_ctrl_dut%0d: got %b expected 110", tag, k,
                 {o_pcw[k], o_ifw[k], o_ifl[k]});
      end
    end
  endtask

  // Front-end controls are combinational: check them mid low phase.
  always @(negedge clk) begin
    #2;
    if (ctrl_q.size() >= 2) begin
      for (int k = 0; k < 2; k++) begin
        logic [2:0] e;
        e = ctrl_q.pop_front();
        n_tests++;
        if ({o_pcw[k], o_ifw[k], o_ifl[k]} !== e) begin
          n_fail++;
          $display("FAIL ctrl_dut%0d @%0t: got %b expected %b", k, $time,
                   {o_pcw[k], o_ifw[k], o_ifl[k]}, e);
        end
      end
    end
  end

  // EX register contents: check just after the capturing edge.
  always @(posedge clk) begin
    #1;
    if (ex_q.size() >= 2) begin
      for (int k = 0; k < 2; k++) begin
        ex_t e;
        e = ex_q.pop_front();
        n_tests++;
        if (actual_ex(k) !== e) begin
          n_fail++;
          $display("FAIL ex_dut%0d @%0t: got %h expected %h", k, $time, actual_ex(k), e);
        end
      end
    end
  end

  initial begin
    stall_len[0] = 1;
    stall_len[1] = 2;
    arst = 1'b1; enable = 1'b1; br = 1'b0;
    rs1_id = 5'd1; rs2_id = 5'd2; rd_id = 5'd3; rw_id = 1'b1; mr_id = 1'b1;
    d1_id = '1; d2_id = '1; imm_id = '1;
    model_reset();
    #2;
    check_reset_state("reset");
    #1;
    arst = 1'b0;

    // Load x5, consumer reads x5 on rs2 and is held in ID while stalled.
    drive(1, 0, 5'd1, 5'd2, 5'd5, 1, 1);
    repeat (3) drive(1, 0, 5'd9, 5'd5, 5'd10, 1, 0);
    // Load into x0 with consumer on rs1 = x0: never stalls.
    drive(1, 0, 5'd3, 5'd4, 5'd0, 1, 1);
    drive(1, 0, 5'd0, 5'd6, 5'd11, 1, 0);
    // Hazard and branch together: branch wins, then one flush cycle.
    drive(1, 0, 5'd1, 5'd2, 5'd5, 1, 1);
    drive(1, 1, 5'd5, 5'd2, 5'd12, 1, 0);
    drive(1, 0, 5'd5, 5'd2, 5'd12, 1, 0);
    drive(1, 0, 5'd1, 5'd2, 5'd13, 1, 0);
    // Freeze three cycles with changing ID, then resume.
    repeat (3) drive(0, 0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                     5'($urandom_range(0, 31)), 1, 1);
    drive(1, 0, 5'd14, 5'd15, 5'd16, 1, 0);
    // ADD x7 then consumer of x7: plain forwarding case, no stall.
    drive(1, 0, 5'd1, 5'd2, 5'd7, 1, 0);
    drive(1, 0, 5'd7, 5'd3, 5'd8, 1, 0);
    drive(1, 0, 5'd1, 5'd2, 5'd3, 0, 0);

    // Async reset while the 2-bubble instance is in its second stall cycle.
    drive(1, 0, 5'd1, 5'd2, 5'd5, 1, 1);
    drive(1, 0, 5'd5, 5'd6, 5'd9, 1, 0);
    @(posedge clk);
    #3;
    n_tests++;
    if (o_pcw[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_before_reset: pc_write got %b expected 0", o_pcw[1]);
    end
    ctrl_q.delete();
    ex_q.delete();
    arst = 1'b1;
    #1;
    check_reset_state("async_reset");
    model_reset();
    #1;
    arst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 11) == 0),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 4));
    end

    repeat (3) @(posedge clk);
    #4;
    n_tests++;
    if (ctrl_q.size() != 0 || ex_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: ctrl_q=%0d ex_q=%0d left, expected 0", ctrl_q.size(), ex_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
